// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and hex-to-segment table for the seg7_scanner slice
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G + 1;

  typedef logic [SEG_W-1:0] seg_t;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

  localparam seg_t SEG_BLANK = 7'h00;

  // Active-high segments, bit SEG_A is the LSB (gfedcba).
  localparam seg_t SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational 4-bit nibble to 7-segment decoder
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = SEG_HEX[nib];

endmodule

// File: rtl/seg7_scanner.sv
// rtl/seg7_scanner.sv - two-digit multiplexed hex display with frame-aligned value swap
// Optional build macro SEG7_LZ_BLANK_EN blanks a zero high digit.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count_in,
  input  logic       count_valid,
  output logic       count_ready,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dig_sel,
  output logic       frame_tick,
  output logic [7:0] uo_out
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  phase_e        ph_q, ph_d;
  logic [7:0]    disp_q, disp_d;
  logic [7:0]    pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  seg_t          seg_q, seg_d;
  logic          dig_sel_q, dig_sel_d;
  logic          frame_tick_q, frame_tick_d;

  logic          pre_last;
  logic          frame_end;
  logic          xfer;
  logic [3:0]    nib;
  seg_t          nib_seg;

  assign pre_last    = (pre_q == PRE_LAST);
  assign frame_end   = pre_last && (ph_q == PH_HI);
  assign count_ready = !pend_vld_q || frame_end;
  assign xfer        = count_valid && count_ready;

  always_comb begin
    pre_d = pre_last ? '0 : pre_q + PW'(1);
    ph_d  = pre_last ? phase_e'(~ph_q) : ph_q;
  end

  // At a frame boundary the pending value moves to the display; a value arriving
  // on that same boundary with nothing pending goes straight to the display.
  always_comb begin
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (frame_end) begin
      if (pend_vld_q) begin
        disp_d     = pend_q;
        pend_vld_d = 1'b0;
        if (xfer) begin
          pend_d     = count_in;
          pend_vld_d = 1'b1;
        end
      end else if (xfer) begin
        disp_d = count_in;
      end
    end else if (xfer) begin
      pend_d     = count_in;
      pend_vld_d = 1'b1;
    end
  end

  assign nib = (ph_q == PH_HI) ? disp_q[7:4] : disp_q[3:0];

  hex_to_seg7 u_dec (
    .nib (nib),
    .seg (nib_seg)
  );

  always_comb begin
    seg_d = nib_seg;
`ifdef SEG7_LZ_BLANK_EN
    if ((ph_q == PH_HI) && (disp_q[7:4] == 4'h0)) begin
      seg_d = SEG_BLANK;
    end
`endif
    if (blank) begin
      seg_d = SEG_BLANK;
    end
    dig_sel_d    = ph_q;
    frame_tick_d = frame_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q        <= '0;
      ph_q         <= PH_LO;
      disp_q       <= 8'h00;
      pend_q       <= 8'h00;
      pend_vld_q   <= 1'b0;
      seg_q        <= SEG_BLANK;
      dig_sel_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      ph_q         <= ph_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = dig_sel_q;
  assign frame_tick = frame_tick_q;
  assign uo_out     = {dig_sel_q, seg_q};

endmodule

// File: tb/tb_seg7_scanner.sv
// tb/tb_seg7_scanner.sv - directed scoreboard bench for seg7_scanner (REFRESH_DIV=4)
module tb_seg7_scanner;

  localparam int RD = 4;
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] HI0 = 7'h00;
`else
  localparam logic [6:0] HI0 = 7'h3F;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] count_in;
  logic       count_valid;
  logic       count_ready;
  logic       blank;
  logic [6:0] seg;
  logic       dig_sel;
  logic       frame_tick;
  logic [7:0] uo_out;

  seg7_scanner #(.REFRESH_DIV(RD)) dut (
    .clk         (clk),
    .rst         (rst),
    .count_in    (count_in),
    .count_valid (count_valid),
    .count_ready (count_ready),
    .blank       (blank),
    .seg         (seg),
    .dig_sel     (dig_sel),
    .frame_tick  (frame_tick),
    .uo_out      (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q [$];
  logic       mon_en = 1'b0;
  logic       armed  = 1'b0;
  logic       torn   = 1'b0;
  int         lo_n   = 0;
  int         hi_n   = 0;
  logic [6:0] lo_seg = 7'h00;
  logic [6:0] hi_seg = 7'h00;
  logic [7:0] last_val = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nib_of(input logic [6:0] s);
    for (int i = 0; i < 16; i++) begin
      if (s === hex_tab[i]) return i;
    end
    return -1;
  endfunction

  function automatic int hi_of(input logic [6:0] s);
    int n;
`ifdef SEG7_LZ_BLANK_EN
    if (s === 7'h00) return 0;
    n = nib_of(s);
    if (n == 0) return -1;
`else
    n = nib_of(s);
`endif
    return n;
  endfunction

  // Frame monitor: collects both digits of each frame, flags torn frames and
  // checks every change of displayed value against the scoreboard.
  task automatic mon_sample();
    int         ln, hn;
    logic [7:0] val, e;
    if (rst) begin
      armed = 1'b0; last_val = 8'h00; lo_n = 0; hi_n = 0; torn = 1'b0;
      return;
    end
    if (!mon_en) begin
      armed = 1'b0;
      return;
    end
    if (dig_sel === 1'b0) begin
      if (lo_n == 0) lo_seg = seg;
      else if (seg !== lo_seg) torn = 1'b1;
      lo_n++;
    end else begin
      if (hi_n == 0) hi_seg = seg;
      else if (seg !== hi_seg) torn = 1'b1;
      hi_n++;
    end
    if (frame_tick === 1'b1) begin
      if (armed) begin
        chk("frame_intact", {29'b0, lo_n == RD, hi_n == RD, !torn}, 32'h7);
        ln = nib_of(lo_seg);
        hn = hi_of(hi_seg);
        chk("frame_decode_ok", {31'b0, (ln >= 0) && (hn >= 0)}, 32'h1);
        if ((ln >= 0) && (hn >= 0)) begin
          val = {hn[3:0], ln[3:0]};
          if (val != last_val) begin
            if (exp_q.size() == 0) begin
              chk("disp_unexpected", {24'b0, val}, {24'b0, last_val});
            end else begin
              e = exp_q.pop_front();
              chk("disp_seq", {24'b0, val}, {24'b0, e});
            end
            last_val = val;
          end
        end
      end
      armed = 1'b1; lo_n = 0; hi_n = 0; torn = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mon_sample();
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (frame_tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, {31'b0, frame_tick}, 32'h1);
  endtask

  initial begin
    int  n;
    logic found_lo, found_hi;

    rst = 1'b1; count_in = 8'h00; count_valid = 1'b0; blank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg",        {25'b0, seg},        32'h00);
    chk("rst_dig_sel",    {31'b0, dig_sel},    32'h0);
    chk("rst_frame_tick", {31'b0, frame_tick}, 32'h0);
    chk("rst_ready",      {31'b0, count_ready}, 32'h1);
    rst = 1'b0;
    chk("rel_seg_hold", {25'b0, seg}, 32'h00);
    mon_en = 1'b1;

    // Idle cadence: dig_sel period RD, frame_tick every 2*RD cycles.
    for (int k = 1; k <= 24; k++) begin
      step();
      chk("idle_dig_sel", {31'b0, dig_sel}, ((k - 1) / RD) % 2);
      chk("idle_tick", {31'b0, frame_tick}, {31'b0, (k % (2 * RD)) == 0});
      chk("idle_seg", {25'b0, seg}, {25'b0, dig_sel ? HI0 : 7'h3F});
    end
    chk("uo_out_map", {24'b0, uo_out}, {24'b0, dig_sel, seg});

    // Single value while idle.
    count_in = 8'hA5; count_valid = 1'b1;
    chk("a5_ready", {31'b0, count_ready}, 32'h1);
    exp_q.push_back(8'hA5);
    step();
    count_valid = 1'b0;
    found_lo = 1'b0;
    for (int i = 1; i <= 9 && !found_lo; i++) begin
      step();
      if (seg === 7'h6D && dig_sel === 1'b0) found_lo = 1'b1;
    end
    chk("a5_lo_latency", {31'b0, found_lo}, 32'h1);
    found_hi = 1'b0;
    for (int i = 1; i <= 2 * RD && !found_hi; i++) begin
      step();
      if (seg === 7'h77 && dig_sel === 1'b1) found_hi = 1'b1;
    end
    chk("a5_hi_seen", {31'b0, found_hi}, 32'h1);

    // Back-to-back values with valid held.
    wait_tick("b2b_sync");
    count_in = 8'h12; count_valid = 1'b1;
    chk("b2b_12_ready", {31'b0, count_ready}, 32'h1);
    exp_q.push_back(8'h12);
    step();
    count_in = 8'h34;
    chk("b2b_ready_drop", {31'b0, count_ready}, 32'h0);
    n = 0;
    while (count_ready !== 1'b1 && n < 20) begin step(); n++; end
    chk("b2b_34_wait", n, 2 * RD - 2);
    exp_q.push_back(8'h34);
    step();
    chk("b2b_34_on_frame_end", {31'b0, frame_tick}, 32'h1);
    count_in = 8'h56;
    chk("b2b_56_ready_low", {31'b0, count_ready}, 32'h0);
    n = 0;
    while (count_ready !== 1'b1 && n < 20) begin step(); n++; end
    chk("b2b_56_wait", n, 2 * RD - 1);
    exp_q.push_back(8'h56);
    step();
    chk("b2b_56_on_frame_end", {31'b0, frame_tick}, 32'h1);
    count_valid = 1'b0;
    repeat (5 * RD) step();

    // Blank for 3 cycles mid low digit of 0x56.
    wait_tick("blank_sync");
    step();
    chk("pre_blank_seg", {25'b0, seg}, 32'h7D);
    mon_en = 1'b0;
    blank = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("blank_seg", {25'b0, seg}, 32'h00);
      chk("blank_dig_sel", {31'b0, dig_sel}, 32'h0);
    end
    blank = 1'b0;
    step();
    chk("post_blank_seg", {25'b0, seg}, 32'h6D);
    chk("post_blank_dig_sel", {31'b0, dig_sel}, 32'h1);
    step(); step();
    chk("blank_tick_low", {31'b0, frame_tick}, 32'h0);
    step();
    chk("blank_tick_cadence", {31'b0, frame_tick}, 32'h1);
    mon_en = 1'b1;

    // Leading zero.
    n = 0;
    while (count_ready !== 1'b1 && n < 20) begin step(); n++; end
    chk("lz_ready", {31'b0, count_ready}, 32'h1);
    count_in = 8'h07; count_valid = 1'b1;
    exp_q.push_back(8'h07);
    step();
    count_valid = 1'b0;
    repeat (5 * RD) step();
    n = 0;
    while (dig_sel !== 1'b1 && n < 20) begin step(); n++; end
    chk("lz_hi_seg", {25'b0, seg}, {25'b0, HI0});
    n = 0;
    while (dig_sel !== 1'b0 && n < 20) begin step(); n++; end
    chk("lz_lo_seg", {25'b0, seg}, 32'h07);

    // Reset mid-frame with 0xFF pending.
    wait_tick("rst_sync");
    count_in = 8'hFF; count_valid = 1'b1;
    step();
    count_valid = 1'b0;
    repeat (5) step();
    chk("pre_rst_dig_sel", {31'b0, dig_sel}, 32'h1);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_seg",     {25'b0, seg},        32'h00);
    chk("async_rst_dig_sel", {31'b0, dig_sel},    32'h0);
    chk("async_rst_tick",    {31'b0, frame_tick}, 32'h0);
    chk("async_rst_ready",   {31'b0, count_ready}, 32'h1);
    step(); step();
    rst = 1'b0;
    mon_en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      chk("post_rst_seg", {25'b0, seg}, {25'b0, dig_sel ? HI0 : 7'h3F});
      chk("post_rst_dig_sel", {31'b0, dig_sel}, ((k - 1) / RD) % 2);
    end
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
